// File: rtl/rot_pkg.sv
// Shared definitions for the multi-cycle rotate unit: direction codes, FSM
// state encoding and stage-count helpers.
package rot_pkg;

  localparam logic ROT_LEFT  = 1'b0;
  localparam logic ROT_RIGHT = 1'b1;

  localparam int SHAMT_W_DEFAULT = 5;
  localparam int STAGES          = SHAMT_W_DEFAULT;

  typedef enum logic {
    IDLE = 1'b0,
    ROT  = 1'b1
  } state_e;

  // Width of a counter able to index every stage of a WIDTH-bit rotator.
  function automatic int stage_idx_w(input int shamt_w);
    return (shamt_w > 1) ? $clog2(shamt_w) : 1;
  endfunction

endpackage

// File: rtl/rot_stage.sv
// One binary stage of a rotator: rotates data by 2^stage_i in direction dir_i
// when en_i is set, otherwise passes data through unchanged.
module rot_stage
  import rot_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int IDX_W   = 3
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             dir_i,
  input  logic [IDX_W-1:0] stage_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] data_o
);

  localparam logic [SHAMT_W:0] WIDTH_L = (SHAMT_W + 1)'(WIDTH);

  logic [SHAMT_W:0]   amt;
  logic [SHAMT_W:0]   amt_inv;
  logic [WIDTH-1:0]   rol;
  logic [WIDTH-1:0]   ror;

  // amt is never 0 or WIDTH, so neither shift below degenerates.
  assign amt     = (SHAMT_W + 1)'(1) << stage_i;
  assign amt_inv = WIDTH_L - amt;
  assign rol     = (data_i << amt) | (data_i >> amt_inv);
  assign ror     = (data_i >> amt) | (data_i << amt_inv);

  always_comb begin
    data_o = data_i;
    if (en_i) begin
      data_o = (dir_i == ROT_RIGHT) ? ror : rol;
    end
  end

endmodule

// File: rtl/seq_rotator.sv
// Multi-cycle rotate unit: applies one power-of-two stage of the rotate amount
// per clock, with a start/busy/done handshake and a held, registered result.
module seq_rotator
  import rot_pkg::*;
#(
  parameter int  WIDTH   = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] a,
  input  logic [31:0]      b,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = stage_idx_w(SHAMT_W);
  localparam logic [IDX_W-1:0] LAST_STAGE = IDX_W'(SHAMT_W - 1);

  state_e             state_q,  state_d;
  logic [WIDTH-1:0]   work_q,   work_d;
  logic [SHAMT_W-1:0] amt_q,    amt_d;
  logic               dir_q,    dir_d;
  logic [IDX_W-1:0]   stage_q,  stage_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;

  logic [WIDTH-1:0]   stage_out;
  logic               unused_b;

  assign unused_b = ^b[31:SHAMT_W];

  rot_stage #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W),
    .IDX_W   (IDX_W)
  ) u_stage (
    .data_i  (work_q),
    .dir_i   (dir_q),
    .stage_i (stage_q),
    .en_i    (amt_q[stage_q]),
    .data_o  (stage_out)
  );

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    amt_d    = amt_q;
    dir_d    = dir_q;
    stage_d  = stage_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = a;
          amt_d   = b[SHAMT_W-1:0];
          dir_d   = dir;
          stage_d = '0;
          busy_d  = 1'b1;
          state_d = ROT;
        end
      end
      ROT: begin
        work_d  = stage_out;
        stage_d = stage_q + 1'b1;
        // The final stage writes straight to result so done lines up with it.
        if (stage_q == LAST_STAGE) begin
          result_d = stage_out;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          stage_d  = '0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      work_q   <= '0;
      amt_q    <= '0;
      dir_q    <= ROT_LEFT;
      stage_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      amt_q    <= amt_d;
      dir_q    <= dir_d;
      stage_q  <= stage_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: doc/seq_rotator.md
Name: seq_rotator

Overview:
- Multi-cycle rotate unit that complements the combinational shr/shra/shl shifters.
- Shifts bits out one end and recirculates them in at the other; supports ROL and ROR.
- Processes one binary stage of the rotate amount per clock (1, 2, 4, 8, 16), with a start/done handshake, for the ALU rotate opcodes.
- Result is registered and held until the next accepted start.

Parameters:
WIDTH, 32, datapath width; must be a power of two.
SHAMT_W, 5, rotate-amount bits used; equals log2(WIDTH); derived, not overridden.

Ports:
clk  input  1  system clock; all state changes on rising edge.
reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
start  input  1  request; accepted only when busy=0.
dir  input  1  0 = rotate left (ROL), 1 = rotate right (ROR); captured at accept.
a  input  WIDTH  operand to rotate; captured at accept.
b  input  32  rotate amount; only b[SHAMT_W-1:0] used, upper bits ignored; captured at accept.
result  output  WIDTH  rotated value; valid when done=1 and held afterwards.
busy  output  1  high while a rotate is in progress.
done  output  1  one-cycle pulse when result is updated.

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - result=0, busy=0, done=0, state=IDLE, stage counter=0.
  - Reset overrides start.
  - Mid-operation reset aborts the operation; no done is produced.
- States:
  - IDLE: busy=0. On start=1, capture a into the working register, b[4:0] into amt, dir into dir_r, set stage=0, go to ROT. done drops to 0 on this edge.
  - ROT: busy=1. Each edge applies stage k=stage to the working register: if amt[k]=1, rotate by 2^k in direction dir_r, else pass through. Then stage increments.
  - On the edge that applies stage SHAMT_W-1: write the working value into result, set done=1, go to IDLE.
- Latency is fixed, independent of amount:
  - start accepted at edge E;
  - result and done=1 visible after edge E+5;
  - done=0 after edge E+6 unless a new start was accepted at E+5, in which case done is still cleared.
- done is registered and high for exactly one cycle per accepted start.
- start while busy=1 is ignored; captured operands are unaffected and no queuing occurs.
- start asserted in the cycle done=1 (state IDLE) is accepted: back-to-back throughput is one op per 6 cycles.
- result holds its last value through IDLE and ROT; it changes only on the completion edge or on reset.
- Rotation is lossless:
  - amount 0 gives result=a;
  - ROL by n equals ROR by (WIDTH-n) mod WIDTH.
- a, b and dir changes after accept have no effect.

Decomposition:
- Shared package rot_pkg:
  - ROT_LEFT=1'b0 and ROT_RIGHT=1'b1 direction constants;
  - state encoding IDLE/ROT;
  - STAGES=SHAMT_W constant.
- One combinational sub-module, rot_stage:
  - inputs: data, dir, stage index, enable bit;
  - output: data rotated by 2^stage, or passed through when enable=0;
  - instantiated once and indexed by the stage counter.
- Top level holds the FSM, stage counter, captured operands, and the result/done registers.

Test Plan:
- ROL a=0x80000001, b=1 -> result=0x00000003, done pulse 5 cycles after accept, busy high for exactly 5 cycles.
- ROR a=0x80000001, b=4 -> 0x18000000; ROL a=0x12345678, b=8 -> 0x34567812; ROR a=0x12345678, b=31 -> 0x2468ACF0.
- b=0 and b=0x00000020 (masked to 0) with a=0xDEADBEEF, either dir -> 0xDEADBEEF; b=0xFFFFFFE1 -> rotate by 1.
- start re-pulsed with different a during busy -> ignored, first result delivered unchanged, single done pulse.
- reset_n=0 on cycle 3 of ROT -> next cycle busy=0, done=0, result=0, no later done; a new start completes normally.
- start held high continuously -> ops accepted every 6 cycles, done pulses each one cycle wide; randomized a/b/dir checked against reference rotate model.
